wb_write_arbiter: RTL and testbench

- Sits in front of the register file's single write port (WE3/A3/WD3). Merges two writer streams onto that port:
  - the in-order pipeline writeback stage, which has fixed priority;
  - the long-latency multiply/divide unit, whose results are buffered in a small FIFO and drained on idle write cycles.
- Reports registers with queued results so the hazard unit can stall readers.

---
 rtl/wb_write_arbiter_pkg.sv | 21 ++
 rtl/wb_write_arbiter_fifo.sv | 103 ++++++++++
 rtl/wb_write_arbiter.sv | 110 +++++++++++
 tb/tb_wb_write_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the register/data widths, the zero-register constant and the
// buffered muldiv result entry type used by the FIFO and the top level.
package wb_write_arbiter_pkg;

  localparam int RA_W = 5;
  localparam int DW   = 32;

  localparam logic [RA_W-1:0] REG_ZERO = 5'd0;

  // One buffered muldiv result. A cleared live bit means the slot is either
  // empty or was superseded by a newer pipeline write to the same register.
  typedef struct packed {
    logic            live;
    logic [RA_W-1:0] addr;
    logic [DW-1:0]   data;
  } wb_entry_t;

  localparam wb_entry_t EMPTY_ENTRY = '{live: 1'b0, addr: 5'd0, data: 32'd0};

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Muldiv result buffer for the write-port arbiter.
// Stores {live, addr, data} entries in arrival order, tracks read/write
// pointers and occupancy, and clears the live bit of every stored entry whose
// address matches a pipeline writeback (WAW kill).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push_valid/addr/data  incoming muldiv result (handshake with ready)
//   ready                 buffer not full (registered count)
//   pop                   drain request for the head entry this cycle
//   kill_en/kill_addr     pipeline write this cycle and its destination
//   head                  entry at the read pointer
//   count                 current occupancy
//   live_vec/addr_vec     per-slot live bits and addresses for hazard compare
module wb_write_arbiter_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_valid,
  input  logic [RA_W-1:0]                 push_addr,
  input  logic [DW-1:0]                   push_data,
  output logic                            ready,
  input  logic                            pop,
  input  logic                            kill_en,
  input  logic [RA_W-1:0]                 kill_addr,
  output wb_entry_t                       head,
  output logic [PTR_W:0]                  count,
  output logic [DEPTH-1:0]                live_vec,
  output logic [DEPTH-1:0][RA_W-1:0]      addr_vec
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;

  logic push_fire_s;
  logic store_s;
  logic do_pop_s;

  assign ready       = (count_r != FULL_CNT);
  assign push_fire_s = push_valid && ready;
  // A handshake to x0 completes but occupies no slot.
  assign store_s     = push_fire_s && (push_addr != REG_ZERO);
  assign do_pop_s    = pop && (count_r != CNT_ZERO);
  assign head        = mem_r[rd_ptr_r];
  assign count       = count_r;

  // Storage, pointers and occupancy; kill, pop and push all act on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= EMPTY_ENTRY;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem_r[i].addr == kill_addr)) begin
          mem_r[i].live <= 1'b0;
        end
      end
      // Popped slots drop their live bit so they never raise a hazard.
      if (do_pop_s) begin
        mem_r[rd_ptr_r].live <= 1'b0;
        rd_ptr_r             <= rd_ptr_r + PTR_ONE;
      end
      // Push and pop never hit the same slot: that needs empty or full.
      if (store_s) begin
        mem_r[wr_ptr_r] <= '{live: !(kill_en && (push_addr == kill_addr)),
                             addr: push_addr,
                             data: push_data};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      case ({store_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Flatten per-slot tag state for the hazard compare in the top level.
  always_comb begin
    live_vec = {DEPTH{1'b0}};
    addr_vec = {DEPTH{REG_ZERO}};
    for (int i = 0; i < DEPTH; i++) begin
      live_vec[i] = mem_r[i].live;
      addr_vec[i] = mem_r[i].addr;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback owns the port whenever it writes a non-zero
// register; otherwise the oldest buffered muldiv result is drained. Queued
// live results are reported to the hazard unit through PEND1/PEND2.
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   WB_WE/WB_A/WB_WD           pipeline writeback (fixed priority)
//   MD_VALID/MD_A/MD_WD        muldiv result, accepted when MD_READY
//   MD_READY                   buffer can accept a result
//   Q_A1/Q_A2, PEND1/PEND2     hazard queries and their pending flags
//   WE3/A3/WD3                 register file write port
//   OCC                        buffer occupancy (debug)
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WB_WE,
  input  logic [RA_W-1:0] WB_A,
  input  logic [DW-1:0]   WB_WD,
  input  logic            MD_VALID,
  input  logic [RA_W-1:0] MD_A,
  input  logic [DW-1:0]   MD_WD,
  output logic            MD_READY,
  input  logic [RA_W-1:0] Q_A1,
  input  logic [RA_W-1:0] Q_A2,
  output logic            PEND1,
  output logic            PEND2,
  output logic            WE3,
  output logic [RA_W-1:0] A3,
  output logic [DW-1:0]   WD3,
  output logic [PTR_W:0]  OCC
);

  localparam logic [PTR_W:0] CNT_ZERO = (PTR_W+1)'(0);

  logic                       wb_hit_s;
  logic                       pop_s;
  wb_entry_t                  head_s;
  logic [PTR_W:0]             count_s;
  logic [DEPTH-1:0]           live_vec_s;
  logic [DEPTH-1:0][RA_W-1:0] addr_vec_s;

  // A write to x0 is not a real write, so it neither blocks draining nor kills.
  assign wb_hit_s = WB_WE && (WB_A != REG_ZERO);
  assign pop_s    = !wb_hit_s && (count_s != CNT_ZERO);
  assign OCC      = count_s;

  wb_write_arbiter_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (CLK),
    .rst        (RST),
    .push_valid (MD_VALID),
    .push_addr  (MD_A),
    .push_data  (MD_WD),
    .ready      (MD_READY),
    .pop        (pop_s),
    .kill_en    (wb_hit_s),
    .kill_addr  (WB_A),
    .head       (head_s),
    .count      (count_s),
    .live_vec   (live_vec_s),
    .addr_vec   (addr_vec_s)
  );

  // Write-port priority mux; the register file writes on negedge, so this is
  // purely combinational. A killed head is popped with the enable held low.
  always_comb begin
    WE3 = 1'b0;
    A3  = REG_ZERO;
    WD3 = 32'd0;
    if (wb_hit_s) begin
      WE3 = !RST;
      A3  = WB_A;
      WD3 = WB_WD;
    end else if (count_s != CNT_ZERO) begin
      WE3 = !RST && head_s.live;
      A3  = head_s.addr;
      WD3 = head_s.data;
    end else begin
      WE3 = 1'b0;
      A3  = REG_ZERO;
      WD3 = 32'd0;
    end
  end

  // Hazard flags from stored state only; the incoming result is not visible.
  always_comb begin
    PEND1 = 1'b0;
    PEND2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_vec_s[i] && (addr_vec_s[i] == Q_A1) && (Q_A1 != REG_ZERO)) begin
        PEND1 = 1'b1;
      end else begin
        PEND1 = PEND1;
      end
      if (live_vec_s[i] && (addr_vec_s[i] == Q_A2) && (Q_A2 != REG_ZERO)) begin
        PEND2 = 1'b1;
      end else begin
        PEND2 = PEND2;
      end
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        CLK;
  logic        RST;
  logic        WB_WE;
  logic [4:0]  WB_A;
  logic [31:0] WB_WD;
  logic        MD_VALID;
  logic [4:0]  MD_A;
  logic [31:0] MD_WD;
  logic        MD_READY;
  logic [4:0]  Q_A1;
  logic [4:0]  Q_A2;
  logic        PEND1;
  logic        PEND2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [PTR_W:0] OCC;

  wb_write_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST),
    .WB_WE(WB_WE), .WB_A(WB_A), .WB_WD(WB_WD),
    .MD_VALID(MD_VALID), .MD_A(MD_A), .MD_WD(MD_WD), .MD_READY(MD_READY),
    .Q_A1(Q_A1), .Q_A2(Q_A2), .PEND1(PEND1), .PEND2(PEND2),
    .WE3(WE3), .A3(A3), .WD3(WD3), .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit        live;
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  ent_t      q[$];
  bit [31:0] rf_m [32];
  bit [31:0] rf_d [32];
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: drive after negedge, compare against the model,
  // then advance the model across the following posedge.
  task automatic drive_cycle(input bit rst, input bit we, input bit [4:0] a,
                             input bit [31:0] wd, input bit mdv, input bit [4:0] mda,
                             input bit [31:0] mdwd, input bit [4:0] qa1, input bit [4:0] qa2);
    bit        hit;
    bit        ew;
    bit [4:0]  ea;
    bit [31:0] ed;
    bit        er;
    bit        ep1;
    bit        ep2;
    bit        pop;
    bit        push;
    @(negedge CLK);
    RST = rst; WB_WE = we; WB_A = a; WB_WD = wd;
    MD_VALID = mdv; MD_A = mda; MD_WD = mdwd; Q_A1 = qa1; Q_A2 = qa2;
    #1;
    hit = we && (a != 5'd0);
    if (hit) begin
      ew = 1'b1; ea = a; ed = wd;
    end else if (q.size() > 0) begin
      ew = q[0].live; ea = q[0].addr; ed = q[0].data;
    end else begin
      ew = 1'b0; ea = 5'd0; ed = 32'd0;
    end
    if (rst) ew = 1'b0;
    er  = (q.size() != DEPTH);
    ep1 = 1'b0;
    ep2 = 1'b0;
    foreach (q[i]) begin
      if (q[i].live && q[i].addr == qa1 && qa1 != 5'd0) ep1 = 1'b1;
      if (q[i].live && q[i].addr == qa2 && qa2 != 5'd0) ep2 = 1'b1;
    end
    check_val("we3", {31'd0, WE3}, {31'd0, ew});
    if (!rst) begin
      check_val("a3", {27'd0, A3}, {27'd0, ea});
      check_val("wd3", WD3, ed);
      check_val("md_ready", {31'd0, MD_READY}, {31'd0, er});
      check_val("occ", {29'd0, OCC}, q.size());
      check_val("pend1", {31'd0, PEND1}, {31'd0, ep1});
      check_val("pend2", {31'd0, PEND2}, {31'd0, ep2});
      if (ew) rf_m[ea] = ed;
      if (WE3 === 1'b1) rf_d[A3] = WD3;
    end
    @(posedge CLK);
    if (rst) begin
      q.delete();
    end else begin
      pop  = !hit && (q.size() > 0);
      push = mdv && er && (mda != 5'd0);
      if (hit) begin
        foreach (q[i]) if (q[i].addr == a) q[i].live = 1'b0;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{live: !(hit && mda == a), addr: mda, data: mdwd});
    end
  endtask

  task automatic idle(input int n, input bit [4:0] qa1);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, qa1, 5'd0);
  endtask

  initial begin
    RST = 1'b1; WB_WE = 1'b0; WB_A = 5'd0; WB_WD = 32'd0;
    MD_VALID = 1'b0; MD_A = 5'd0; MD_WD = 32'd0; Q_A1 = 5'd0; Q_A2 = 5'd0;
    for (int i = 0; i < 32; i++) begin rf_m[i] = 32'd0; rf_d[i] = 32'd0; end

    // Reset then idle.
    drive_cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    drive_cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(1, 5'd8);

    // Single muldiv result drains on the next idle cycle.
    drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd8, 32'h1234, 5'd8, 5'd0);
    idle(2, 5'd8);
    check_val("md_r8", rf_d[8], 32'h1234);

    // Contention: pipeline holds the port for three cycles.
    drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd9, 32'hAAAA, 5'd9, 5'd0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 1, 5'd3, 32'h300 + i, 0, 5'd0, 32'd0, 5'd9, 5'd0);
    idle(2, 5'd9);
    check_val("cont_r9", rf_d[9], 32'hAAAA);

    // Fill while pipeline busy, hold a fifth result, then release.
    for (int i = 0; i < 4; i++)
      drive_cycle(0, 1, 5'd3, 32'h33, 1, 5'd10 + i, 32'hA0 + i, 5'd10, 5'd13);
    for (int i = 0; i < 2; i++)
      drive_cycle(0, 1, 5'd3, 32'h33, 1, 5'd14, 32'hE0, 5'd14, 5'd0);
    for (int i = 0; i < 2; i++)
      drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd14, 32'hE0, 5'd14, 5'd0);
    idle(6, 5'd0);
    check_val("fill_r14", rf_d[14], 32'hE0);

    // WAW kill: newer pipeline write must survive.
    drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1111, 5'd5, 5'd0);
    drive_cycle(0, 1, 5'd5, 32'h2222, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(2, 5'd5);
    check_val("waw_r5", rf_d[5], 32'h2222);

    // Corner cases: push to x0, x0 writeback does not block draining.
    drive_cycle(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
    drive_cycle(0, 1, 5'd0, 32'h55, 1, 5'd7, 32'h7777, 5'd7, 5'd0);
    drive_cycle(0, 1, 5'd0, 32'h55, 0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(1, 5'd7);
    check_val("x0_r7", rf_d[7], 32'h7777);

    // Reset with three queued entries: none may ever be written.
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 1, 5'd3, 32'h44, 1, 5'd20 + i, 32'hBAD0 + i, 5'd20, 5'd0);
    drive_cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd20, 5'd0);
    idle(4, 5'd20);
    check_val("rst_r20", rf_d[20], 32'd0);

    // Randomized traffic on a narrow register range to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      drive_cycle($urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(8, 5'd0);

    for (int r = 0; r < 32; r++) check_val($sformatf("rf_r%0d", r), rf_d[r], rf_m[r]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
